axis_pattern_source: RTL and testbench
======================================

AXIS_PATTERN_SOURCE -- requirements
Module: axis_pattern_source

Interface
REQ-001 SHALL have parameter OUTPUT_BYTES, default 3, bytes per pixel beat.
REQ-002 SHALL have parameter OUTPUT_BITS, default OUTPUT_BYTES*8, data width.
REQ-003 SHALL have parameter DIM_BITS, default 12, width of the frame-dimension inputs and internal x/y counters.
REQ-004 SHALL have ports, one per line:
- clk_i  in  1  sole clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  single-cycle request to begin a frame
- continuous_i  in  1  1 = auto-restart after each frame
- width_i  in  DIM_BITS  pixels per line
- height_i  in  DIM_BITS  lines per frame
- pattern_i  in  2  pattern select
- color_i  in  OUTPUT_BITS  solid-pattern value
- axis_m_data_o  out  OUTPUT_BITS  pixel data
- axis_m_valid_o  out  1  AXI-Stream valid
- axis_m_ready_i  in  1  AXI-Stream ready from sink
- axis_m_last_o  out  1  end of line, set on last pixel of each line
- axis_m_user_o  out  1  start of frame, set on pixel (0,0) only
- busy_o  out  1  frame in progress
- frame_done_o  out  1  one-cycle pulse after the last beat of a frame is accepted

Function
REQ-005 SHALL implement states IDLE, ACTIVE.
REQ-006 SHALL, in IDLE, on start_i=1 with width_i!=0 and height_i!=0, latch width_i, height_i, pattern_i, color_i, set x=0, y=0 and enter ACTIVE the next cycle.
REQ-007 SHALL ignore start_i when width_i or height_i is 0, and whenever the state is ACTIVE.
REQ-008 SHALL hold axis_m_valid_o=1 for every ACTIVE cycle, with no gaps between beats while axis_m_ready_i=1.
REQ-009 SHALL count a beat as transferred only when axis_m_valid_o and axis_m_ready_i are both 1 on a rising edge.
REQ-010 SHALL keep data, last and user stable while valid=1 and ready=0.
REQ-011 SHALL, on a transfer, set x=x+1; if x=width-1, set x=0 and y=y+1.
REQ-012 SHALL drive axis_m_last_o=1 iff x=width-1, and axis_m_user_o=1 iff x=0 and y=0.
REQ-013 SHALL derive data combinationally from the current x, y and latched settings; x, y are zero-extended or truncated to OUTPUT_BITS:
- pattern 0: x
- pattern 1: y
- pattern 2: all-ones if x[3]^y[3] else all-zeros
- pattern 3: latched color
REQ-014 SHALL, on transfer of beat (width-1, height-1), pulse frame_done_o for the following cycle.
REQ-015 SHALL at that same beat, if continuous_i=1, relatch width_i/height_i/pattern_i/color_i (only if both dims are nonzero), reset x=y=0 and stay in ACTIVE with no idle cycle.
REQ-016 SHALL at that same beat enter IDLE if continuous_i=0 or a new dimension is 0.
REQ-017 SHALL drive busy_o=1 exactly when the state is ACTIVE.
REQ-018 SHALL handle a 1x1 frame as one beat with user=1, last=1 and a frame_done_o pulse.
REQ-019 SHALL drive valid=0 in IDLE; data, last and user in IDLE are don't-care.

Reset
REQ-020 SHALL, while rst_i=1, asynchronously force IDLE, x=y=0, axis_m_valid_o=0, axis_m_last_o=0, axis_m_user_o=0, busy_o=0, frame_done_o=0, and latched settings to 0.
REQ-021 SHALL, on reset asserted mid-frame, abandon the frame, produce no frame_done_o pulse, and require a new start_i after release.
REQ-022 SHALL not begin a frame in the first cycle after reset release unless start_i=1 in that cycle.

Verification
REQ-023 SHALL cover: width=4, height=2, pattern 0, ready held 1 -> 8 consecutive beats, data 0,1,2,3,0,1,2,3; user on beat 0 only; last on beats 3 and 7; frame_done_o 1 cycle later; busy_o falls.
REQ-024 SHALL cover: width=3, height=3, pattern 1, ready toggled 1,0,0,1,... -> outputs frozen while ready=0; data sequence 0,0,0,1,1,1,2,2,2 over 9 transfers.
REQ-025 SHALL cover: width=1, height=1, pattern 3, color=0xA5A5A5 -> one beat 0xA5A5A5 with user=1, last=1; frame_done_o pulse.
REQ-026 SHALL cover: continuous_i=1, width=2, height=2 -> back-to-back frames, user on beats 0 and 4, no valid gap; drop continuous_i -> IDLE after the current frame.
REQ-027 SHALL cover: start_i with width=0 -> stays IDLE, valid=0; start_i pulsed mid-frame -> ignored, counts unaffected.
REQ-028 SHALL cover: rst_i asserted at beat 5 of an 8x8 frame -> valid=0 immediately, no frame_done_o; a new start yields user=1 on data 0.

Source files
------------

// File: rtl/axis_pattern_source.sv
`default_nettype none
// ============================================================================
// Module      : axis_pattern_source
// Description : AXI-Stream video test-pattern generator. Emits width x height
//               pixel beats per frame (ramp in x, ramp in y, 8x8 checker, or
//               solid colour), with TLAST at end of line and TUSER at start of
//               frame. Optional back-to-back frame generation.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pattern_source #(
  parameter int OUTPUT_BYTES = 3,
  parameter int OUTPUT_BITS  = OUTPUT_BYTES * 8,
  parameter int DIM_BITS     = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   continuous_i,
  input  logic [DIM_BITS-1:0]    width_i,
  input  logic [DIM_BITS-1:0]    height_i,
  input  logic [1:0]             pattern_i,
  input  logic [OUTPUT_BITS-1:0] color_i,
  output logic [OUTPUT_BITS-1:0] axis_m_data_o,
  output logic                   axis_m_valid_o,
  input  logic                   axis_m_ready_i,
  output logic                   axis_m_last_o,
  output logic                   axis_m_user_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam logic [DIM_BITS-1:0] c_DIM_ONE = DIM_BITS'(1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [DIM_BITS-1:0]    x_q, x_d;
  logic [DIM_BITS-1:0]    y_q, y_d;
  logic [DIM_BITS-1:0]    width_q, width_d;
  logic [DIM_BITS-1:0]    height_q, height_d;
  logic [1:0]             pattern_q, pattern_d;
  logic [OUTPUT_BITS-1:0] color_q, color_d;
  logic                   frame_done_q, frame_done_d;

  logic                   w_active;
  logic                   w_xfer;
  logic                   w_x_end;
  logic                   w_y_end;
  logic                   w_new_dims_ok;
  logic [OUTPUT_BITS-1:0] w_x_fit;
  logic [OUTPUT_BITS-1:0] w_y_fit;
  logic [OUTPUT_BITS-1:0] w_data;

  assign w_active      = (state_q == S_ACTIVE);
  assign w_xfer        = w_active & axis_m_ready_i;
  assign w_x_end       = (x_q == (width_q - c_DIM_ONE));
  assign w_y_end       = (y_q == (height_q - c_DIM_ONE));
  assign w_new_dims_ok = (width_i != '0) && (height_i != '0);

  // Fit the coordinate counters onto the pixel bus (zero-extend or truncate).
  if (OUTPUT_BITS > DIM_BITS) begin : g_zext
    assign w_x_fit = {{(OUTPUT_BITS-DIM_BITS){1'b0}}, x_q};
    assign w_y_fit = {{(OUTPUT_BITS-DIM_BITS){1'b0}}, y_q};
  end else if (OUTPUT_BITS == DIM_BITS) begin : g_same
    assign w_x_fit = x_q;
    assign w_y_fit = y_q;
  end else begin : g_trunc
    assign w_x_fit = x_q[OUTPUT_BITS-1:0];
    assign w_y_fit = y_q[OUTPUT_BITS-1:0];
  end

  // Pixel value is a pure function of the current position and latched setup,
  // so it stays frozen for as long as the sink stalls.
  always_comb begin
    w_data = '0;
    case (pattern_q)
      2'd0:    w_data = w_x_fit;
      2'd1:    w_data = w_y_fit;
      2'd2:    w_data = (x_q[3] ^ y_q[3]) ? '1 : '0;
      default: w_data = color_q;
    endcase
  end

  // State and counter registers; reset clears everything including the setup.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      width_q      <= '0;
      height_q     <= '0;
      pattern_q    <= '0;
      color_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      width_q      <= width_d;
      height_q     <= height_d;
      pattern_q    <= pattern_d;
      color_q      <= color_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: start a frame from IDLE, advance the raster on each accepted
  // beat, and on the final beat either reload for another frame or stop.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    width_d      = width_q;
    height_d     = height_q;
    pattern_d    = pattern_q;
    color_d      = color_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && w_new_dims_ok) begin
          width_d   = width_i;
          height_d  = height_i;
          pattern_d = pattern_i;
          color_d   = color_i;
          x_d       = '0;
          y_d       = '0;
          state_d   = S_ACTIVE;
        end
      end
      default: begin
        if (w_xfer) begin
          if (w_x_end) begin
            x_d = '0;
            if (w_y_end) begin
              y_d          = '0;
              frame_done_d = 1'b1;
              if (continuous_i && w_new_dims_ok) begin
                width_d   = width_i;
                height_d  = height_i;
                pattern_d = pattern_i;
                color_d   = color_i;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              y_d = y_q + c_DIM_ONE;
            end
          end else begin
            x_d = x_q + c_DIM_ONE;
          end
        end
      end
    endcase
  end

  assign axis_m_data_o  = w_data;
  assign axis_m_valid_o = w_active;
  assign axis_m_last_o  = w_active & w_x_end;
  assign axis_m_user_o  = w_active & (x_q == '0) & (y_q == '0);
  assign busy_o         = w_active;
  assign frame_done_o   = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_pattern_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pattern_source
// Description : Self-checking bench for axis_pattern_source. Expected pixels
//               come from a raster model (beat index -> x, y -> pattern value).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pattern_source;

  localparam int OB = 24;
  localparam int DB = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic [DB-1:0] width = '0;
  logic [DB-1:0] height = '0;
  logic [1:0]    pattern = '0;
  logic [OB-1:0] color = '0;
  logic [OB-1:0] data;
  logic          valid;
  logic          ready = 1'b0;
  logic          last;
  logic          user;
  logic          busy;
  logic          fdone;

  int errors = 0;
  int checks = 0;

  axis_pattern_source #(.OUTPUT_BYTES(3), .OUTPUT_BITS(OB), .DIM_BITS(DB)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .continuous_i   (cont),
    .width_i        (width),
    .height_i       (height),
    .pattern_i      (pattern),
    .color_i        (color),
    .axis_m_data_o  (data),
    .axis_m_valid_o (valid),
    .axis_m_ready_i (ready),
    .axis_m_last_o  (last),
    .axis_m_user_o  (user),
    .busy_o         (busy),
    .frame_done_o   (fdone)
  );

  always #5 clk = ~clk;

  // Raster model: 8x8 checker tiles alternate by parity of tile coordinates.
  function automatic logic [OB-1:0] model_pixel(input int p, input int x, input int y,
                                                input logic [OB-1:0] c);
    case (p)
      0:       return OB'(x);
      1:       return OB'(y);
      2:       return (((x / 8) + (y / 8)) % 2 == 1) ? {OB{1'b1}} : {OB{1'b0}};
      default: return c;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; leaves us at the negedge after the
  // start edge, where beat 0 is presented.
  task automatic do_start(input int w, input int h, input int p, input logic [OB-1:0] c,
                          input logic cn);
    width = DB'(w); height = DB'(h); pattern = 2'(p); color = c; cont = cn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walk nbeats beats of a w x h frame. prob<0 selects ready pattern 1,0,0,...
  task automatic run_frame(input int w, input int h, input int p, input logic [OB-1:0] c,
                           input int prob, input logic fd_first, input int nbeats,
                           input bit poke);
    int  k = 0;
    int  cyc = 0;
    bit  first = 1'b1;
    logic xfer;
    while (k < nbeats && cyc < 3000) begin
      chk("valid", valid, 1);
      chk("busy", busy, 1);
      chk("data", data, model_pixel(p, k % w, k / w, c));
      chk("last", last, ((k % w) == (w - 1)) ? 1 : 0);
      chk("user", user, (k == 0) ? 1 : 0);
      chk("frame_done", fdone, first ? fd_first : 1'b0);
      first = 1'b0;
      if (prob < 0) ready = (cyc % 3 == 0);
      else          ready = ($urandom_range(0, 99) < prob);
      if (poke) begin
        start  = ($urandom_range(0, 1) == 1);
        width  = DB'($urandom_range(1, 7));
        height = DB'($urandom_range(1, 7));
      end
      @(posedge clk);
      xfer = ready;
      @(negedge clk);
      if (xfer) k++;
      cyc++;
    end
    if (poke) start = 1'b0;
    if (k < nbeats) chk("timeout_beats", k, nbeats);
  endtask

  // At the negedge after the final beat of a non-continuous frame.
  task automatic end_check();
    chk("done_pulse", fdone, 1);
    chk("valid_after", valid, 0);
    chk("busy_after", busy, 0);
    @(negedge clk);
    chk("done_single", fdone, 0);
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", last, 0);
    chk("rst_user", user, 0);
    chk("rst_done", fdone, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", valid, 0);

    // 4x2 ramp in x, sink always ready.
    do_start(4, 2, 0, 24'h0, 1'b0);
    run_frame(4, 2, 0, 24'h0, 100, 1'b0, 8, 1'b0);
    end_check();

    // 3x3 ramp in y, ready 1,0,0 repeating.
    do_start(3, 3, 1, 24'h0, 1'b0);
    run_frame(3, 3, 1, 24'h0, -1, 1'b0, 9, 1'b0);
    end_check();

    // 1x1 solid colour.
    do_start(1, 1, 3, 24'hA5A5A5, 1'b0);
    run_frame(1, 1, 3, 24'hA5A5A5, 100, 1'b0, 1, 1'b0);
    end_check();

    // Continuous: two 2x2 frames back to back, then a relatched 20x2 checker
    // frame after which continuous is dropped.
    do_start(2, 2, 0, 24'h0, 1'b1);
    run_frame(2, 2, 0, 24'h0, 100, 1'b0, 4, 1'b0);
    width = DB'(20); height = DB'(2); pattern = 2'd2; color = 24'h123456;
    run_frame(2, 2, 0, 24'h0, 100, 1'b1, 4, 1'b0);
    cont = 1'b0;
    width = DB'(5); height = DB'(5); pattern = 2'd0;
    run_frame(20, 2, 2, 24'h123456, 70, 1'b1, 40, 1'b0);
    end_check();

    // Zero dimensions are rejected.
    width = '0; height = DB'(3); start = 1'b1;
    @(negedge clk);
    chk("zero_w_valid", valid, 0);
    width = DB'(3); height = '0;
    @(negedge clk);
    chk("zero_h_busy", busy, 0);
    start = 1'b0;

    // Randomised frames with start pulses poked in while active.
    for (int i = 0; i < 6; i++) begin
      int w, h, p, pr;
      logic [OB-1:0] c;
      w  = $urandom_range(1, 20);
      h  = $urandom_range(1, 5);
      p  = $urandom_range(0, 3);
      pr = $urandom_range(30, 100);
      c  = OB'($urandom);
      do_start(w, h, p, c, 1'b0);
      run_frame(w, h, p, c, pr, 1'b0, w * h, 1'b1);
      end_check();
    end

    // Reset in the middle of an 8x8 frame, with beat 5 on the bus.
    do_start(8, 8, 0, 24'h0, 1'b0);
    run_frame(8, 8, 0, 24'h0, 100, 1'b0, 5, 1'b0);
    chk("mid_beat5_data", data, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    chk("mid_rst_done", fdone, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_idle", valid, 0);
    chk("mid_rel_done", fdone, 0);
    do_start(8, 8, 0, 24'h0, 1'b0);
    run_frame(8, 8, 0, 24'h0, 100, 1'b0, 64, 1'b0);
    end_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
